// File: rtl/debounce3_sync.sv
// Three-channel synchronizer and debouncer with per-channel change pulses
// and a registered "any asserted" flag aligned with the clean levels.
module debounce3_sync #(
    parameter int WIDTH  = 4,
    parameter int STABLE = 10
) (
    input  logic C,
    input  logic R,
    input  logic CE,
    input  logic I0,
    input  logic I1,
    input  logic I2,
    output logic O0,
    output logic O1,
    output logic O2,
    output logic CHG0,
    output logic CHG1,
    output logic CHG2,
    output logic ANY
);

    generate
        if (STABLE < 1 || STABLE > (1 << WIDTH)) begin : g_bad_stable
            $error("debounce3_sync: STABLE out of range 1..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST = WIDTH'(STABLE - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       lvl;
    logic [2:0]       lvl_n;
    logic [2:0]       chg;
    logic [2:0]       chg_n;
    logic [WIDTH-1:0] cnt   [3];
    logic [WIDTH-1:0] cnt_n [3];
    logic             any;

    assign raw = {I2, I1, I0};

    // A return to the held level cancels a pending change outright.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lvl_n[i] = lvl[i];
            chg_n[i] = 1'b0;
            cnt_n[i] = cnt[i];
            if (s2[i] == lvl[i]) begin
                cnt_n[i] = '0;
            end else if (CE) begin
                if (cnt[i] == LAST) begin
                    lvl_n[i] = s2[i];
                    cnt_n[i] = '0;
                    chg_n[i] = 1'b1;
                end else begin
                    cnt_n[i] = cnt[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge C) begin
        if (!R) begin
            s1  <= '0;
            s2  <= '0;
            lvl <= '0;
            chg <= '0;
            any <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1  <= raw;
            s2  <= s1;
            lvl <= lvl_n;
            chg <= chg_n;
            any <= |lvl_n;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_n[i];
            end
        end
    end

    assign O0   = lvl[0];
    assign O1   = lvl[1];
    assign O2   = lvl[2];
    assign CHG0 = chg[0];
    assign CHG1 = chg[1];
    assign CHG2 = chg[2];
    assign ANY  = any;

endmodule

// File: tb/tb_debounce3_sync.sv
// Scoreboard bench for debounce3_sync: a STABLE=4 build and a STABLE=1 build.
// Expected vectors are {O2,O1,O0,CHG2,CHG1,CHG0,ANY} keyed by edge number.
module tb_debounce3_sync;

    logic C = 1'b0;
    logic R;
    logic CE;
    logic a0, a1, a2;
    logic b0, b1, b2;
    logic ao0, ao1, ao2, ac0, ac1, ac2, aany;
    logic bo0, bo1, bo2, bc0, bc1, bc2, bany;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        string      tag;
        bit         dut;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];

    debounce3_sync #(.WIDTH(3), .STABLE(4)) u_dut4 (
        .C(C), .R(R), .CE(CE),
        .I0(a0), .I1(a1), .I2(a2),
        .O0(ao0), .O1(ao1), .O2(ao2),
        .CHG0(ac0), .CHG1(ac1), .CHG2(ac2),
        .ANY(aany)
    );

    debounce3_sync #(.WIDTH(3), .STABLE(1)) u_dut1 (
        .C(C), .R(R), .CE(CE),
        .I0(b0), .I1(b1), .I2(b2),
        .O0(bo0), .O1(bo1), .O2(bo2),
        .CHG0(bc0), .CHG1(bc1), .CHG2(bc2),
        .ANY(bany)
    );

    always #5 C = ~C;

    always @(posedge C) cyc <= cyc + 1;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b expected %b",
                     tag, cyc, got[6:0], exp[6:0]);
        end
    endtask

    task automatic push_exp(int c, string tag, bit d, logic [6:0] v);
        sb.push_back('{c, tag, d, v});
    endtask

    task automatic push_range(int c0, int c1, string tag, bit d,
                              logic [6:0] v);
        for (int c = c0; c <= c1; c++) push_exp(c, tag, d, v);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge C);
    endtask

    always @(negedge C) begin
        logic [6:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = sb[i].dut ? {bo2, bo1, bo0, bc2, bc1, bc0, bany}
                                : {ao2, ao1, ao0, ac2, ac1, ac0, aany};
                check_eq(sb[i].tag, {25'd0, got}, {25'd0, sb[i].exp});
                sb.delete(i);
            end
        end
    end

    initial begin
        R  = 1'b0;
        CE = 1'b1;
        {a2, a1, a0} = 3'b111;
        {b2, b1, b0} = 3'b000;

        // reset held for three edges, then release with all inputs high
        push_exp(3, "reset", 0, 7'b000_000_0);
        push_exp(3, "reset1", 1, 7'b000_000_0);
        wait_cyc(3);
        R = 1'b1;
        push_exp(8, "pre_rise", 0, 7'b000_000_0);
        push_exp(9, "rise", 0, 7'b111_111_1);
        push_exp(10, "rise_hold", 0, 7'b111_000_1);

        // simultaneous fall
        wait_cyc(11);
        {a2, a1, a0} = 3'b000;
        push_exp(16, "pre_fall", 0, 7'b111_000_1);
        push_exp(17, "fall", 0, 7'b000_111_0);
        push_exp(18, "fall_hold", 0, 7'b000_000_0);

        // 3-cycle bounce is swallowed, 4-cycle pulse passes
        wait_cyc(20);
        a1 = 1'b1;
        push_range(21, 30, "bounce", 0, 7'b000_000_0);
        wait_cyc(23);
        a1 = 1'b0;
        wait_cyc(30);
        a1 = 1'b1;
        push_exp(35, "pre_b4", 0, 7'b000_000_0);
        push_exp(36, "b4_rise", 0, 7'b010_010_1);
        push_range(37, 39, "b4_hold", 0, 7'b010_000_1);
        push_exp(40, "b4_fall", 0, 7'b000_010_0);
        push_exp(41, "b4_idle", 0, 7'b000_000_0);
        wait_cyc(34);
        a1 = 1'b0;

        // CE gating
        wait_cyc(45);
        CE = 1'b0;
        a2 = 1'b1;
        push_range(46, 68, "ce_frozen", 0, 7'b000_000_0);
        push_exp(69, "ce_rise", 0, 7'b100_100_1);
        push_exp(70, "ce_hold", 0, 7'b100_000_1);
        wait_cyc(65);
        CE = 1'b1;
        wait_cyc(72);
        a2 = 1'b0;
        push_range(73, 79, "ce_gap", 0, 7'b100_000_1);
        push_exp(80, "ce_fall", 0, 7'b000_100_0);
        push_exp(81, "ce_idle", 0, 7'b000_000_0);
        wait_cyc(75);
        CE = 1'b0;
        wait_cyc(77);
        CE = 1'b1;

        // reset in the middle of a pending count
        wait_cyc(85);
        a0 = 1'b1;
        push_range(86, 95, "rst_mid", 0, 7'b000_000_0);
        push_exp(96, "rst_rise", 0, 7'b001_001_1);
        push_exp(97, "rst_hold", 0, 7'b001_000_1);
        wait_cyc(89);
        R = 1'b0;
        wait_cyc(90);
        R = 1'b1;

        // STABLE=1 build: pure synchronizer delay
        wait_cyc(100);
        b1 = 1'b1;
        push_exp(102, "s1_pre", 1, 7'b000_000_0);
        push_exp(103, "s1_rise", 1, 7'b010_010_1);
        push_exp(104, "s1_hold", 1, 7'b010_000_1);
        wait_cyc(106);
        b1 = 1'b0;
        push_exp(108, "s1_hi", 1, 7'b010_000_1);
        push_exp(109, "s1_fall", 1, 7'b000_010_0);
        push_exp(110, "s1_idle", 1, 7'b000_000_0);

        wait_cyc(115);
        check_eq("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
